// File: rtl/mmu_arb_pkg.sv
// -----------------------------------------------------------------------------
// mmu_arb_pkg
// Shared constants for the MMU lookup arbiter. It holds the FSM state encoding,
// the grant side encoding, the page-entry present bit, and the tag field
// boundaries used by the optional per-side hit caches.
// -----------------------------------------------------------------------------
package mmu_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Grant encoding (grant_o / last grant)
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // A page entry with this bit clear is reported to the requester as an error
    localparam int ENT_PRESENT_BIT = 0;

    // The virtual page number is used as the hit-cache tag
    localparam int PAGE_TAG_MSB = 31;
    localparam int PAGE_TAG_LSB = 12;
    localparam int TAG_W        = PAGE_TAG_MSB - PAGE_TAG_LSB + 1;

    function automatic logic [TAG_W-1:0] page_tag(input logic [31:0] addr);
        return addr[PAGE_TAG_MSB:PAGE_TAG_LSB];
    endfunction

endpackage

// File: rtl/mmu_arb_hit_cache.sv
// -----------------------------------------------------------------------------
// mmu_arb_hit_cache
// One-entry translation register for one requester side. It remembers the
// last error-free page entry together with the page tag it belongs to.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (entry invalid)
//   lookup_tag_i   page tag of the address currently being requested
//   hit_o          valid entry whose tag equals lookup_tag_i
//   hit_ent_o      stored page entry (meaningful only with hit_o)
//   fill_i         write fill_tag_i / fill_ent_i and mark the entry valid
//   fill_tag_i     tag to store
//   fill_ent_i     entry to store
//   flush_i        invalidate; wins over a fill in the same cycle
// -----------------------------------------------------------------------------
module mmu_arb_hit_cache
    import mmu_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [31:0]      hit_ent_o,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [31:0]      fill_ent_i,
    input  logic             flush_i
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      ent_q, ent_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ent_d   = ent_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            ent_d   = fill_ent_i;
        end
        // A flush means the page table changed under us, so a fill
        // landing in the same cycle is already stale.
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ent_q   <= ent_d;
        end
    end

    assign hit_o     = valid_q && (tag_q == lookup_tag_i);
    assign hit_ent_o = ent_q;

endmodule

// File: rtl/mmu_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_lookup_arbiter
// Shares the single MMU translation port between the instruction-fetch and the
// data-access requesters. It arbitrates round-robin and keeps one lookup in
// flight. It issues a one-cycle lookup pulse and waits for the MMU acknowledge
// under a WAIT_LIMIT watchdog. The page entry and an error flag go back to the
// winning side with a one-cycle ack.
//
// Build option: define MMU_ARB_HIT_CACHE_EN to give each side a one-entry hit
// cache. A hit skips the MMU and answers one cycle after the request. Without
// the macro every request goes to the MMU and flush_i is ignored.
//
// Parameters:
//   WAIT_LIMIT     cycles counted in WAIT before the lookup times out
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req/i_addr            instruction request, held with stable addr until i_ack
//   i_ent/i_err/i_ack       instruction response, ent/err qualified by i_ack
//   d_req/d_addr            data request
//   d_ent/d_err/d_ack       data response
//   flush_i                 invalidate hit caches (page-table base rewritten)
//   mmu_addr_o              latched virtual address presented to the MMU
//   mmu_lookup_o            one-cycle lookup pulse
//   mmu_ent_i/mmu_ack_i     MMU result and completion pulse
//   busy_o                  FSM not idle
//   grant_o                 current / last granted side (0 = I, 1 = D)
// -----------------------------------------------------------------------------
module mmu_lookup_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_ent,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic [31:0] d_ent,
    output logic        d_ack,
    output logic        d_err,
    input  logic        flush_i,
    output logic [31:0] mmu_addr_o,
    output logic        mmu_lookup_o,
    input  logic [31:0] mmu_ent_i,
    input  logic        mmu_ack_i,
    output logic        busy_o,
    output logic        grant_o
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             lookup_q, lookup_d;
    logic             busy_q;
    logic             i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic             i_err_q, i_err_d, d_err_q, d_err_d;
    logic [31:0]      i_ent_q, i_ent_d, d_ent_q, d_ent_d;

    // Hit-cache interface (tied off when the caches are not built)
    logic        i_hit, d_hit;
    logic [31:0] i_hit_ent, d_hit_ent;

`ifdef MMU_ARB_HIT_CACHE_EN
    logic i_fill, d_fill;

    // Only good translations are remembered; fills happen in RESP from the
    // response registers that were loaded on the way in.
    assign i_fill = (state_q == ST_RESP) && (grant_q == GRANT_I) && !i_err_q;
    assign d_fill = (state_q == ST_RESP) && (grant_q == GRANT_D) && !d_err_q;

    mmu_arb_hit_cache u_i_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_tag_i (page_tag(i_addr)),
        .hit_o        (i_hit),
        .hit_ent_o    (i_hit_ent),
        .fill_i       (i_fill),
        .fill_tag_i   (page_tag(addr_q)),
        .fill_ent_i   (i_ent_q),
        .flush_i      (flush_i)
    );

    mmu_arb_hit_cache u_d_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_tag_i (page_tag(d_addr)),
        .hit_o        (d_hit),
        .hit_ent_o    (d_hit_ent),
        .fill_i       (d_fill),
        .fill_tag_i   (page_tag(addr_q)),
        .fill_ent_i   (d_ent_q),
        .flush_i      (flush_i)
    );
`else
    logic unused_flush;

    assign i_hit        = 1'b0;
    assign d_hit        = 1'b0;
    assign i_hit_ent    = '0;
    assign d_hit_ent    = '0;
    assign unused_flush = flush_i;
`endif

    // Response staging, routed to the granted side after the case statement
    logic        sel;
    logic        sel_hit;
    logic [31:0] sel_hit_ent;
    logic        rsp_fire;
    logic [31:0] rsp_ent;
    logic        rsp_err;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        lookup_d     = 1'b0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;
        i_ent_d      = i_ent_q;
        d_ent_d      = d_ent_q;
        rsp_fire     = 1'b0;
        rsp_ent      = '0;
        rsp_err      = 1'b0;

        // Round-robin: with both sides pending, serve the one not served last
        sel         = (i_req && d_req) ? ~last_grant_q : d_req;
        sel_hit     = sel ? d_hit : i_hit;
        sel_hit_ent = sel ? d_hit_ent : i_hit_ent;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant_d = sel;
                    addr_d  = sel ? d_addr : i_addr;
                    if (sel_hit) begin
                        state_d  = ST_RESP;
                        rsp_fire = 1'b1;
                        rsp_ent  = sel_hit_ent;
                        rsp_err  = 1'b0;
                    end else begin
                        state_d  = ST_ISSUE;
                        lookup_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack arriving in the timeout cycle still completes normally
                if (mmu_ack_i) begin
                    state_d  = ST_RESP;
                    rsp_fire = 1'b1;
                    rsp_ent  = mmu_ent_i;
                    rsp_err  = ~mmu_ent_i[ENT_PRESENT_BIT];
                end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
                    state_d  = ST_RESP;
                    rsp_fire = 1'b1;
                    rsp_ent  = '0;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The ack and its entry/err are registered together on entry to RESP
        if (rsp_fire) begin
            if (grant_d == GRANT_D) begin
                d_ack_d = 1'b1;
                d_ent_d = rsp_ent;
                d_err_d = rsp_err;
            end else begin
                i_ack_d = 1'b1;
                i_ent_d = rsp_ent;
                i_err_d = rsp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_D;
            cnt_q        <= '0;
            addr_q       <= '0;
            lookup_q     <= 1'b0;
            busy_q       <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_ent_q      <= '0;
            d_ent_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            lookup_q     <= lookup_d;
            busy_q       <= (state_d != ST_IDLE);
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
            i_ent_q      <= i_ent_d;
            d_ent_q      <= d_ent_d;
        end
    end

    assign i_ent        = i_ent_q;
    assign i_ack        = i_ack_q;
    assign i_err        = i_err_q;
    assign d_ent        = d_ent_q;
    assign d_ack        = d_ack_q;
    assign d_err        = d_err_q;
    assign mmu_addr_o   = addr_q;
    assign mmu_lookup_o = lookup_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_mmu_lookup_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mmu_lookup_arbiter
// Drives the arbiter with directed and $urandom transactions against a
// transaction-level model: expected latency, entry, error, arbitration order
// and lookup counts come from the protocol rules. A behavioural MMU answers
// each lookup after a chosen or random delay.
// -----------------------------------------------------------------------------
module tb_mmu_lookup_arbiter;

    localparam int WL = 8;
`ifdef MMU_ARB_HIT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, flush_i, mmu_ack_i;
    logic [31:0] i_addr, d_addr, mmu_ent_i;
    logic [31:0] i_ent, d_ent, mmu_addr_o;
    logic        i_ack, i_err, d_ack, d_err, mmu_lookup_o, busy_o, grant_o;

    always #5 clk = ~clk;

    mmu_lookup_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ent        (i_ent),
        .i_ack        (i_ack),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_ent        (d_ent),
        .d_ack        (d_ack),
        .d_err        (d_err),
        .flush_i      (flush_i),
        .mmu_addr_o   (mmu_addr_o),
        .mmu_lookup_o (mmu_lookup_o),
        .mmu_ent_i    (mmu_ent_i),
        .mmu_ack_i    (mmu_ack_i),
        .busy_o       (busy_o),
        .grant_o      (grant_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lookups  = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst_n && mmu_lookup_o) lookups <= lookups + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural MMU ----------------
    typedef struct {
        logic [31:0] ent;
        logic        err;
        int          lat;   // request-sampled -> requester-ack cycles
    } rsp_t;

    rsp_t        mmu_q[$];
    int          plan_delay  = 0;   // 0: random (0 = silent), -1: silent, >0: fixed
    logic [31:0] plan_ent    = '0;
    bit          plan_ent_en = 1'b0;

    initial begin : responder
        int          k;
        logic [31:0] e;
        rsp_t        r;
        mmu_ack_i = 1'b0;
        mmu_ent_i = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mmu_lookup_o) begin
                k = (plan_delay != 0) ? plan_delay : int'($urandom_range(0, WL + 1));
                e = plan_ent_en ? plan_ent : $urandom;
                // Lookup in cycle L, WAIT spans L+1..L+1+WL; ack in cycle L+k
                if (k >= 1 && k <= WL + 1) begin
                    r.ent = e;
                    r.err = ~e[0];
                    r.lat = k + 2;
                end else begin
                    r.ent = '0;
                    r.err = 1'b1;
                    r.lat = WL + 3;
                end
                mmu_q.push_back(r);
                if (k >= 1) begin
                    repeat (k) @(posedge clk);
                    #1 mmu_ack_i = 1'b1;
                    mmu_ent_i = e;
                    @(posedge clk);
                    #1 mmu_ack_i = 1'b0;
                    mmu_ent_i = $urandom;
                end
            end
        end
    end

    // ---------------- reference model state ----------------
    bit          c_valid[2];
    logic [19:0] c_tag[2];
    logic [31:0] c_ent[2];
    bit          last_served = 1'b1;

    function automatic bit model_hit(input bit s, input logic [31:0] a);
        return CACHE_EN && c_valid[s] && (c_tag[s] == a[31:12]);
    endfunction

    task automatic model_reset();
        c_valid     = '{1'b0, 1'b0};
        last_served = 1'b1;
        mmu_q.delete();
    endtask

    // Called at the negedge of an ack cycle for expected side s
    task automatic check_resp(input bit s, input logic [31:0] addr, input bit hit,
                              input int lk_before, output int exp_lat);
        rsp_t r;
        check_eq("one_ack", 32'(i_ack && d_ack), 32'd0);
        check_eq("ack_side", 32'(d_ack), 32'(s));
        check_eq("grant_o", 32'(grant_o), 32'(s));
        check_eq("mmu_addr", mmu_addr_o, addr);
        if (hit) begin
            r.ent = c_ent[s];
            r.err = 1'b0;
            r.lat = 1;
            check_eq("lookups_hit", 32'(lookups - lk_before), 32'd0);
        end else begin
            check_eq("lookups_miss", 32'(lookups - lk_before), 32'd1);
            if (mmu_q.size() > 0) begin
                r = mmu_q.pop_front();
            end else begin
                r.ent = '0;
                r.err = 1'b1;
                r.lat = WL + 3;
            end
        end
        check_eq(s ? "d_ent" : "i_ent", s ? d_ent : i_ent, r.ent);
        check_eq(s ? "d_err" : "i_err", 32'(s ? d_err : i_err), 32'(r.err));
        if (!r.err) begin
            c_valid[s] = 1'b1;
            c_tag[s]   = addr[31:12];
            c_ent[s]   = r.ent;
        end
        last_served = s;
        exp_lat     = r.lat;
    endtask

    task automatic idle_gap(input int n);
        int stray, lk0;
        stray = 0;
        lk0   = lookups;
        repeat (n) begin
            @(negedge clk);
            if (i_ack || d_ack) stray++;
        end
        check_eq("stray_ack", 32'(stray), 32'd0);
        check_eq("idle_lookups", 32'(lookups - lk0), 32'd0);
        check_eq("idle_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic do_single(input bit s, input logic [31:0] addr, input int delay,
                             input logic [31:0] ent, input bit ent_en, input int gap);
        bit hit, got;
        int t0, lk0, exp_lat;
        hit         = model_hit(s, addr);
        plan_delay  = delay;
        plan_ent    = ent;
        plan_ent_en = ent_en;
        @(posedge clk);
        #1;
        if (s) begin
            d_req  = 1'b1;
            d_addr = addr;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        t0  = cyc;
        lk0 = lookups;
        got = 1'b0;
        for (int n = 0; n < WL + 20 && !got; n++) begin
            @(negedge clk);
            got = i_ack || d_ack;
        end
        if (got) begin
            check_resp(s, addr, hit, lk0, exp_lat);
            check_eq("latency", 32'(cyc - t0), 32'(exp_lat));
        end else begin
            check_eq("ack_timeout", 32'd0, 32'd1);
        end
        $display("txn side=%0d addr=%08h hit=%0d lat=%0d ent=%08h err=%0d", s, addr, hit,
                 cyc - t0, s ? d_ent : i_ent, s ? d_err : i_err);
        i_req = 1'b0;
        d_req = 1'b0;
        idle_gap(gap);
    endtask

    task automatic both_held(input int n);
        int          acks, lk_prev, exp_lat;
        bit          s;
        logic [31:0] a;
        plan_delay  = 0;
        plan_ent_en = 1'b0;
        @(posedge clk);
        #1;
        i_addr  = $urandom;
        d_addr  = $urandom;
        i_req   = 1'b1;
        d_req   = 1'b1;
        acks    = 0;
        lk_prev = lookups;
        for (int c = 0; c < n * (WL + 8) && acks < n; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                s = ~last_served;
                a = s ? d_addr : i_addr;
                check_resp(s, a, model_hit(s, a), lk_prev, exp_lat);
                $display("rr ack=%0d side=%0d ent=%08h err=%0d", acks, d_ack,
                         d_ack ? d_ent : i_ent, d_ack ? d_err : i_err);
                lk_prev = lookups;
                if (d_ack) d_addr = $urandom;
                else       i_addr = $urandom;
                acks++;
            end
        end
        check_eq("rr_acks", 32'(acks), 32'(n));
        i_req = 1'b0;
        d_req = 1'b0;
        idle_gap(3);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        c_valid = '{1'b0, 1'b0};
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_i_ack"}, 32'(i_ack), 32'd0);
        check_eq({pfx, "_d_ack"}, 32'(d_ack), 32'd0);
        check_eq({pfx, "_i_err"}, 32'(i_err), 32'd0);
        check_eq({pfx, "_d_err"}, 32'(d_err), 32'd0);
        check_eq({pfx, "_lookup"}, 32'(mmu_lookup_o), 32'd0);
        check_eq({pfx, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({pfx, "_grant"}, 32'(grant_o), 32'd0);
        check_eq({pfx, "_i_ent"}, i_ent, 32'd0);
        check_eq({pfx, "_d_ent"}, d_ent, 32'd0);
        check_eq({pfx, "_mmu_addr"}, mmu_addr_o, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        flush_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_gap(2);

        // Basic miss: MMU acks 4 cycles after lookup -> ack at lookup+5
        do_single(1'b0, 32'h0040_1000, 4, 32'h1234_5001, 1'b1, 3);
        // Non-present entry -> error, and never cached
        do_single(1'b1, 32'h0000_5000, 2, 32'h0000_2000, 1'b1, 3);
        do_single(1'b1, 32'h0000_5000, 1, 32'h0000_2000, 1'b1, 3);
        // MMU ack in the timeout cycle itself still completes normally
        do_single(1'b0, 32'h0000_6000, WL + 1, 32'h0BAD_0001, 1'b1, 3);
        // Silent MMU -> timeout 11 cycles after request sampled
        do_single(1'b0, 32'h0000_7000, -1, 32'h0, 1'b0, 3);
        // Late ack after the timeout must be ignored
        do_single(1'b1, 32'h0000_8000, WL + 4, 32'h7777_0001, 1'b1, 20);

        // Hit-cache sequence (plain misses when the cache is not built)
        do_single(1'b1, 32'h8000_0010, 3, 32'hABCD_E001, 1'b1, 3);
        do_single(1'b1, 32'h8000_0FFC, 3, 32'h1111_1001, 1'b1, 3);
        pulse_flush();
        do_single(1'b1, 32'h8000_0FFC, 2, 32'h2222_2001, 1'b1, 3);

        // Reset while waiting on the MMU
        plan_delay  = -1;
        plan_ent_en = 1'b0;
        @(posedge clk);
        #1;
        d_req  = 1'b1;
        d_addr = 32'h0000_9000;
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre_reset_busy", 32'(busy_o), 32'd1);
        check_eq("pre_reset_grant", 32'(grant_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        $display("reset asserted during WAIT");
        d_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_gap(2);
        do_single(1'b1, 32'h0000_9000, 2, 32'h5555_0001, 1'b1, 3);

        // Both requesters held: strict alternation
        both_held(8);

        // Random singles over a small page pool so hits and refills occur
        for (int n = 0; n < 40; n++) begin
            a = {20'h10000 + 20'($urandom_range(0, 3)), 12'($urandom)};
            if ($urandom_range(0, 7) == 0) pulse_flush();
            do_single(1'($urandom_range(0, 1)), a, 0, 32'h0, 1'b0, int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_lookup_arbiter.md
# mmu_lookup_arbiter

Shares the single translation port of the page-table MMU between the instruction-fetch and data-access requesters. Sequences each lookup pulse, waits for the MMU acknowledge with a bounded watchdog, and returns the page entry and an error flag to the winning requester. Round-robin arbitration, one lookup in flight. Sits between the CPU front end and the MMU's v_addr_i/v_lookup/v_ent_o/v_ack_o port.

## Interface
- WAIT_LIMIT, 255: max cycles in WAIT before a timeout error; counter width $clog2(WAIT_LIMIT+1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction lookup request; held high, i_addr stable, until i_ack.
- i_addr  in  32  instruction virtual address.
- i_ent  out  32  page entry for i_addr; valid only while i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack: timeout or entry bit0 (present) clear.
- d_req, d_addr, d_ent, d_ack, d_err: same as i_*, data side.
- flush_i  in  1  pulse: invalidate hit caches (page-table base rewritten).
- mmu_addr_o  out  32  latched virtual address to MMU.
- mmu_lookup_o  out  1  one-cycle lookup pulse.
- mmu_ent_i  in  32  MMU entry output.
- mmu_ack_i  in  1  MMU completion pulse.
- busy_o  out  1  high in any state but IDLE.
- grant_o  out  1  0 = instruction, 1 = data; current/last grant.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: no req -> stay. One req -> grant it. Both -> grant the side not served last (last_grant, reset 1 so instruction wins first). Latch addr into mmu_addr_o -> ISSUE (or RESP on cache hit, see Configuration).
- ISSUE: mmu_lookup_o=1 for exactly this cycle; clear wait counter -> WAIT.
- WAIT: mmu_ack_i=1 -> latch mmu_ent_i, err=~mmu_ent_i[0] -> RESP. Else counter++; counter==WAIT_LIMIT -> err=1, entry=0 -> RESP. mmu_ack_i in the timeout cycle takes priority (normal completion).
- RESP: pulse granted side's ack with latched entry/err; other side's ack stays 0; last_grant<=grant -> IDLE.
- mmu_ack_i outside WAIT ignored.
- Requester dropping req mid-transaction: transaction still completes, ack still pulsed; requester ignores it.
- req still high in cycle after ack = new request.
- Reset (any state, async): state IDLE; all acks, errs, mmu_lookup_o, busy_o = 0; i_ent, d_ent, mmu_addr_o = 0; grant_o=0, last_grant=1; counter 0; hit caches invalid.

## Timing
- Request sampled in IDLE at cycle T; mmu_lookup_o at T+1; WAIT from T+2.
- MMU ack at cycle A (≥T+2) -> requester ack at A+1. Minimum miss latency req->ack: 3 cycles.
- After RESP, at least one IDLE cycle; next mmu_lookup_o ≥2 cycles after previous mmu_ack_i, matching the MMU END->IDLE recovery.
- Timeout: ack at T+2+WAIT_LIMIT+1 when MMU never acks.
- Outputs registered; i_ent/d_ent/i_err/d_err held at last value, qualified only by ack.

## Configuration
- MMU_ARB_HIT_CACHE_EN defined: each side keeps one entry {valid, tag=addr[31:12], ent}. In IDLE, granted side's addr[31:12]==tag and valid -> skip MMU, RESP next cycle (req->ack 1 cycle, err=0). Filled in RESP only when err=0. flush_i clears both valids; flush_i coinciding with a fill -> cleared. Arbitration order unchanged by hits.
- Undefined: no caches, every request goes through ISSUE/WAIT; flush_i ignored.

## Structure
- Package mmu_arb_pkg: state encoding localparams, GRANT_I=0/GRANT_D=1, ENT_PRESENT_BIT=0, PAGE_TAG_MSB/LSB (31/12).
- Sub-module mmu_arb_hit_cache: one-entry translation register (lookup, fill, flush), instantiated twice under MMU_ARB_HIT_CACHE_EN.

## Test plan
- Single i_req, addr 0x0040_1000, MMU acks 4 cycles after lookup with 0x1234_5001 -> i_ack at lookup+5, i_ent=0x1234_5001, i_err=0, d_ack never.
- i_req and d_req both held from cycle 0 -> grants I, D, I, D alternately; exactly one mmu_lookup_o per transaction; never two acks in one cycle.
- MMU returns 0x0000_2000 (bit0=0) -> d_ack with d_err=1, d_ent=0x0000_2000; with cache enabled, repeat request still reaches MMU.
- WAIT_LIMIT=8, MMU silent -> i_ack with i_err=1, i_ent=0 exactly 11 cycles after request sampled; late mmu_ack_i ignored.
- rst_n low during WAIT -> immediately IDLE, all outputs 0; post-reset first request sees fresh lookup pulse.
- Cache enabled: d_addr 0x8000_0010 miss then 0x8000_0FFC -> second ack 1 cycle after request, no mmu_lookup_o; after flush_i, same address re-issues lookup.
